// File: rtl/stepdown_deadtime_ctrl.sv
// stepdown_deadtime_ctrl: break-before-make HS/LS gate sequencer with dead-time, min-on time and gate-sense fault latching.
// Defining DIODE_EMULATION_EN adds the OFF_DCM state entered from LS on inductor zero-cross.
module stepdown_deadtime_ctrl #(
   parameter int DT_W   = 6,
   parameter int MIN_ON = 4,
   parameter int ACK_TO = 15
) (
   input  logic            CELCLK,
   input  logic            CELRSTN,
   input  logic            CELV,
   input  logic            CELG,
   input  logic            SUB,
   input  logic            en,
   input  logic            pwm_req,
   input  logic [DT_W-1:0] dt_lh,
   input  logic [DT_W-1:0] dt_hl,
   input  logic            hs_sense,
   input  logic            ls_sense,
   input  logic            zc,
   output logic            hs_on,
   output logic            ls_on,
   output logic            fault,
   output logic [2:0]      state_o
);
   localparam int TO_W = $clog2(ACK_TO + 1);
`ifdef DIODE_EMULATION_EN
   typedef enum logic [2:0] {OFF = 3'd0, LS = 3'd1, DT_LH = 3'd2, HS = 3'd3, DT_HL = 3'd4, FAULT = 3'd5, OFF_DCM = 3'd6} state_t;
`else
   typedef enum logic [2:0] {OFF = 3'd0, LS = 3'd1, DT_LH = 3'd2, HS = 3'd3, DT_HL = 3'd4, FAULT = 3'd5} state_t;
`endif
   state_t          state, nxt;
   logic [DT_W-1:0] dt_cnt, mo_cnt, dt_sel;
   logic [TO_W-1:0] to_cnt;
   logic            dt_zero, to_hit, dt_entry, stuck, unused;
   assign unused   = ^{CELV, CELG, SUB, zc};
   assign dt_zero  = dt_cnt == '0;
   assign to_hit   = to_cnt == TO_W'(ACK_TO - 1);
   assign dt_sel   = (nxt == DT_LH) ? dt_lh : dt_hl;
   assign dt_entry = (nxt == DT_LH || nxt == DT_HL) && nxt != state;
   assign stuck    = dt_zero && ((state == DT_LH && ls_sense) || (state == DT_HL && hs_sense));
   assign state_o  = state;
   always_comb begin
      nxt = state;
      if (!en)
         nxt = OFF;
      else if (hs_sense && ls_sense)
         nxt = FAULT;
      else
         case (state)
            OFF:     nxt = DT_HL;
`ifdef DIODE_EMULATION_EN
            LS:      nxt = pwm_req ? DT_LH : zc ? OFF_DCM : LS;
            OFF_DCM: nxt = pwm_req ? DT_LH : OFF_DCM;
`else
            LS:      nxt = pwm_req ? DT_LH : LS;
`endif
            DT_LH:   nxt = !dt_zero ? DT_LH : !ls_sense ? HS : to_hit ? FAULT : DT_LH;
            HS:      nxt = (mo_cnt == '0 && !pwm_req) ? DT_HL : HS;
            DT_HL:   nxt = !dt_zero ? DT_HL : !hs_sense ? LS : to_hit ? FAULT : DT_HL;
            FAULT:   nxt = FAULT;
            default: nxt = OFF;
         endcase
   end
   // Counters are loaded with N-1 so a DT or HS state lasts exactly N cycles; a zero dead-time behaves as one.
   always_ff @(posedge CELCLK or negedge CELRSTN)
      if (!CELRSTN) begin
         state  <= OFF;
         dt_cnt <= '0;
         mo_cnt <= '0;
         to_cnt <= '0;
         hs_on  <= 1'b0;
         ls_on  <= 1'b0;
         fault  <= 1'b0;
      end else begin
         state  <= nxt;
         dt_cnt <= dt_entry ? ((dt_sel == '0) ? '0 : dt_sel - 1'b1) : dt_zero ? '0 : dt_cnt - 1'b1;
         mo_cnt <= (nxt == HS && state != HS) ? DT_W'(MIN_ON - 1) : (mo_cnt == '0) ? '0 : mo_cnt - 1'b1;
         to_cnt <= dt_entry ? '0 : stuck ? to_cnt + 1'b1 : to_cnt;
         hs_on  <= nxt == HS;
         ls_on  <= nxt == LS;
         fault  <= nxt == FAULT;
      end
endmodule

// File: tb/tb_stepdown_deadtime_ctrl.sv
// tb_stepdown_deadtime_ctrl: vector table, hand sequences and randomized run against an elapsed-time reference model.
module tb_stepdown_deadtime_ctrl;
   localparam int DT_W = 6, MIN_ON = 4, ACK_TO = 15;
`ifdef DIODE_EMULATION_EN
   localparam bit DE = 1'b1;
`else
   localparam bit DE = 1'b0;
`endif
   logic            clk = 1'b0, rst_n = 1'b0, en = 1'b0, pwm = 1'b0, hs_s = 1'b0, ls_s = 1'b0, zc = 1'b0;
   logic [DT_W-1:0] dt_lh = '0, dt_hl = '0;
   logic            hs_on, ls_on, fault;
   logic [2:0]      state_o;
   logic [5:0]      obs;
   int              checks = 0, errors = 0;
   int              m = 0, age = 0, dtv = 1;
   typedef struct {
      logic            en, pwm, hs_s, ls_s;
      logic [DT_W-1:0] dt_lh, dt_hl;
      int              st;
   } vec_t;
   vec_t tv[23];
   always #5 clk = ~clk;
   assign obs = {hs_on, ls_on, fault, state_o};
   stepdown_deadtime_ctrl #(.DT_W(DT_W), .MIN_ON(MIN_ON), .ACK_TO(ACK_TO)) dut (
      .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
      .en(en), .pwm_req(pwm), .dt_lh(dt_lh), .dt_hl(dt_hl),
      .hs_sense(hs_s), .ls_sense(ls_s), .zc(zc),
      .hs_on(hs_on), .ls_on(ls_on), .fault(fault), .state_o(state_o)
   );
   function automatic int enc(int st);
      return int'({st == 3, st == 1, st == 5, 3'(st)});
   endfunction
   function automatic vec_t v(bit e, bit p, bit h, bit l, int lh, int hl, int st);
      vec_t r;
      r.en = e; r.pwm = p; r.hs_s = h; r.ls_s = l;
      r.dt_lh = DT_W'(lh); r.dt_hl = DT_W'(hl); r.st = st;
      return r;
   endfunction
   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // Reference: each state is left after having been resident for a number of cycles, measured as elapsed time.
   task automatic model_step();
      int ns, a;
      a = age + 1;
      ns = m;
      if (!en) ns = 0;
      else if (hs_s && ls_s) ns = 5;
      else
         case (m)
            0: ns = 4;
            1: ns = pwm ? 2 : (DE && zc) ? 6 : 1;
            2: if (a >= dtv) ns = !ls_s ? 3 : (a - dtv + 1 >= ACK_TO) ? 5 : 2;
            3: if (a >= MIN_ON && !pwm) ns = 4;
            4: if (a >= dtv) ns = !hs_s ? 1 : (a - dtv + 1 >= ACK_TO) ? 5 : 4;
            6: ns = pwm ? 2 : 6;
            default: ns = m;
         endcase
      if (ns != m) begin
         age = 0;
         if (ns == 2) dtv = (dt_lh == 0) ? 1 : int'(dt_lh);
         if (ns == 4) dtv = (dt_hl == 0) ? 1 : int'(dt_hl);
      end else age = a;
      m = ns;
   endtask
   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; pwm = 1'b0; hs_s = 1'b0; ls_s = 1'b0; zc = 1'b0;
      m = 0; age = 0; dtv = 1;
      cyc();
      cyc();
      chk("reset_state", int'(obs), 0);
      rst_n = 1'b1;
   endtask
   initial begin
      int n;
      bit st_h, st_l;
      tv[0]  = v(1,0,0,0,5,3,4);  tv[1]  = v(1,0,0,0,5,3,4);  tv[2]  = v(1,0,0,0,5,3,4);
      tv[3]  = v(1,0,0,0,5,3,1);  tv[4]  = v(1,1,0,1,5,3,2);  tv[5]  = v(1,1,0,0,5,3,2);
      tv[6]  = v(1,0,0,0,5,3,2);  tv[7]  = v(1,0,0,0,5,3,2);  tv[8]  = v(1,0,0,0,5,3,2);
      tv[9]  = v(1,0,0,0,5,3,3);  tv[10] = v(1,0,1,0,5,3,3);  tv[11] = v(1,0,1,0,5,3,3);
      tv[12] = v(1,0,1,0,5,3,3);  tv[13] = v(1,0,1,0,5,3,4);  tv[14] = v(1,0,0,0,5,0,4);
      tv[15] = v(1,0,0,0,5,0,4);  tv[16] = v(1,0,0,0,5,0,1);  tv[17] = v(1,1,0,1,0,0,2);
      tv[18] = v(1,1,0,0,0,0,3);  tv[19] = v(1,0,1,0,0,0,3);  tv[20] = v(1,0,1,1,0,0,5);
      tv[21] = v(1,0,0,0,0,0,5);  tv[22] = v(0,0,0,0,0,0,0);
      do_reset();
      foreach (tv[i]) begin
         en = tv[i].en; pwm = tv[i].pwm; hs_s = tv[i].hs_s; ls_s = tv[i].ls_s;
         dt_lh = tv[i].dt_lh; dt_hl = tv[i].dt_hl;
         cyc();
         chk($sformatf("vec%0d", i), int'(obs), enc(tv[i].st));
      end
      // Acknowledge timeout: LS gate-sense stuck high through DT_LH.
      en = 1'b1; dt_hl = DT_W'(1); pwm = 1'b0; hs_s = 1'b0; ls_s = 1'b0;
      cyc();
      cyc();
      chk("to_reach_ls", int'(obs), enc(1));
      pwm = 1'b1; dt_lh = DT_W'(2); ls_s = 1'b1;
      cyc();
      pwm = 1'b0;
      n = 0;
      while (state_o != 3'd5 && n < 40) begin
         cyc();
         n++;
      end
      chk("to_latency", n, 2 + ACK_TO - 1);
      chk("to_fault", int'(obs), enc(5));
      ls_s = 1'b0;
      repeat (3) cyc();
      chk("to_latched", int'(obs), enc(5));
      en = 1'b0;
      cyc();
      chk("to_clear", int'(obs), enc(0));
`ifdef DIODE_EMULATION_EN
      en = 1'b1; dt_hl = DT_W'(1);
      cyc();
      cyc();
      zc = 1'b1;
      cyc();
      chk("de_off_dcm", int'(obs), enc(6));
      zc = 1'b0; pwm = 1'b1; dt_lh = DT_W'(3);
      cyc();
      chk("de_dt_lh", int'(obs), enc(2));
      cyc();
      cyc();
      chk("de_dt_hold", int'(obs), enc(2));
      cyc();
      chk("de_hs", int'(obs), enc(3));
`endif
      do_reset();
      st_h = 1'b0; st_l = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         en = $urandom_range(99) != 0;
         if ($urandom_range(7) == 0) pwm = ~pwm;
         zc = $urandom_range(9) == 0;
         dt_lh = DT_W'($urandom_range(5));
         dt_hl = DT_W'($urandom_range(5));
         st_h = st_h ? ($urandom_range(7) != 0) : ($urandom_range(99) == 0);
         st_l = st_l ? ($urandom_range(7) != 0) : ($urandom_range(99) == 0);
         hs_s = (m == 3) || st_h;
         ls_s = (m == 1) || st_l;
         model_step();
         cyc();
         chk("random", int'(obs), enc(m));
         if (hs_on && ls_on) chk("overlap", 1, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
